// File: rtl/agen_pkg.sv
// agen_pkg: shared types and helpers for the address-generation stage.
// Size codes, FSM states, channel scan and byte-count helpers.
package agen_pkg;

  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;
  localparam logic [1:0] SZ_8B = 2'd3;

  localparam int MAX_CH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CHAN,
    SPLIT2
  } state_t;

  // Lowest set bit at or above 'from'; MAX_CH when none.
  function automatic logic [5:0] next_set(
    input logic [MAX_CH-1:0] m,
    input logic [5:0]        from
  );
    logic [5:0] r;
    r = 6'(MAX_CH);
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (m[i] && (6'(i) >= from)) r = 6'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] bytes_of(
    input logic [1:0] size
  );
    logic [3:0] b;
    unique case (size)
      SZ_1B:   b = 4'd1;
      SZ_2B:   b = 4'd2;
      SZ_4B:   b = 4'd4;
      SZ_8B:   b = 4'd8;
      default: b = 4'd1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/agen_ea_calc.sv
// agen_ea_calc: effective/linear address, limit fault and line split
// for a single memory-operand channel.
module agen_ea_calc
  import agen_pkg::*;
#(
  parameter int AW     = 32,
  parameter int LINE_B = 64
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] index,
  input  logic [AW-1:0] disp,
  input  logic          use_base,
  input  logic          use_index,
  input  logic [1:0]    scale,
  input  logic [1:0]    size,
  input  logic [AW-1:0] seg_base,
  input  logic [AW-1:0] seg_limit,
  output logic [AW-1:0] ea,
  output logic [AW-1:0] lin,
  output logic          fault,
  output logic          split,
  output logic [AW-1:0] half2
);

  localparam int LB_W = $clog2(LINE_B);

  logic [AW-1:0]  t_base;
  logic [AW-1:0]  t_idx;
  logic [3:0]     nbytes;
  logic [AW:0]    end_a;
  logic [LB_W:0]  off_sum;

  assign t_base = use_base  ? base  : '0;
  assign t_idx  = use_index ? index : '0;
  assign ea     = t_base + (t_idx << scale) + disp;
  assign lin    = seg_base + ea;
  assign nbytes = bytes_of(size);

  // Last byte touched, kept one bit wider so wrap past 2^AW faults.
  assign end_a = {1'b0, ea} + (AW+1)'(nbytes) - (AW+1)'(1);
  assign fault = end_a > {1'b0, seg_limit};

  assign off_sum = {1'b0, lin[LB_W-1:0]} + (LB_W+1)'(nbytes);
  assign split   = !fault && (off_sum > (LB_W+1)'(LINE_B));
  assign half2   = (lin & ~AW'(LINE_B - 1)) + AW'(LINE_B);

endmodule

// File: rtl/agen_stage.sv
// agen_stage: captures a multi-operand transaction and serialises
// one output beat per memory access (two for a line split).
module agen_stage
  import agen_pkg::*;
#(
  parameter  int AW     = 32,
  parameter  int NCH    = 2,
  parameter  int LINE_B = 64,
  parameter  int PAY_W  = 64,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH-1:0]    in_is_mem,
  input  logic [NCH*AW-1:0] in_base,
  input  logic [NCH*AW-1:0] in_index,
  input  logic [NCH*AW-1:0] in_disp,
  input  logic [NCH-1:0]    in_use_base,
  input  logic [NCH-1:0]    in_use_index,
  input  logic [NCH*2-1:0]  in_scale,
  input  logic [NCH*2-1:0]  in_size,
  input  logic [NCH*AW-1:0] in_seg_base,
  input  logic [NCH*AW-1:0] in_seg_limit,
  input  logic [PAY_W-1:0]  in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_addr,
  output logic [CW-1:0]     out_chan,
  output logic              out_mem,
  output logic              out_split,
  output logic              out_half,
  output logic              out_fault,
  output logic              out_last,
  output logic [1:0]        out_size,
  output logic [PAY_W-1:0]  out_payload
);

  state_t state, state_n;

  logic [CW-1:0]     cur;
  logic [AW-1:0]     h2_addr;
  logic [NCH-1:0]    cap_is_mem;
  logic [NCH*AW-1:0] cap_base;
  logic [NCH*AW-1:0] cap_index;
  logic [NCH*AW-1:0] cap_disp;
  logic [NCH-1:0]    cap_use_base;
  logic [NCH-1:0]    cap_use_index;
  logic [NCH*2-1:0]  cap_scale;
  logic [NCH*2-1:0]  cap_size;
  logic [NCH*AW-1:0] cap_seg_base;
  logic [NCH*AW-1:0] cap_seg_limit;
  logic [PAY_W-1:0]  cap_payload;

  logic          accept, pop;
  logic [NCH-1:0] src_mask;
  logic [5:0]    nxt_cap, first_in, sel, after_sel;
  logic [CW-1:0] ch;
  logic          any, more, h2_last;
  logic          ld_ch, ld_h2, ld_nm, clr;

  logic [AW-1:0] e_base, e_index, e_disp;
  logic [AW-1:0] e_seg_base, e_seg_limit;
  logic          e_use_base, e_use_index;
  logic [1:0]    e_scale, e_size;
  logic [AW-1:0] c_ea, c_lin, c_half2;
  logic          c_fault, c_split;

  assign in_ready = (state == IDLE) && !flush &&
                    (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  assign src_mask  = accept ? in_is_mem : cap_is_mem;
  assign nxt_cap   = next_set(MAX_CH'(cap_is_mem), 6'(cur) + 6'd1);
  assign first_in  = next_set(MAX_CH'(in_is_mem), 6'd0);
  assign sel       = accept ? first_in : nxt_cap;
  assign ch        = CW'(sel);
  assign any       = sel < 6'(NCH);
  assign after_sel = next_set(MAX_CH'(src_mask), sel + 6'd1);
  assign more      = after_sel < 6'(NCH);
  assign h2_last   = !(nxt_cap < 6'(NCH));

  // First beat is computed straight from the inputs on accept.
  assign e_base      = accept ? in_base[ch*AW +: AW]
                              : cap_base[ch*AW +: AW];
  assign e_index     = accept ? in_index[ch*AW +: AW]
                              : cap_index[ch*AW +: AW];
  assign e_disp      = accept ? in_disp[ch*AW +: AW]
                              : cap_disp[ch*AW +: AW];
  assign e_seg_base  = accept ? in_seg_base[ch*AW +: AW]
                              : cap_seg_base[ch*AW +: AW];
  assign e_seg_limit = accept ? in_seg_limit[ch*AW +: AW]
                              : cap_seg_limit[ch*AW +: AW];
  assign e_use_base  = accept ? in_use_base[ch]
                              : cap_use_base[ch];
  assign e_use_index = accept ? in_use_index[ch]
                              : cap_use_index[ch];
  assign e_scale     = accept ? in_scale[ch*2 +: 2]
                              : cap_scale[ch*2 +: 2];
  assign e_size      = accept ? in_size[ch*2 +: 2]
                              : cap_size[ch*2 +: 2];

  agen_ea_calc #(
    .AW     (AW),
    .LINE_B (LINE_B)
  ) u_ea (
    .base      (e_base),
    .index     (e_index),
    .disp      (e_disp),
    .use_base  (e_use_base),
    .use_index (e_use_index),
    .scale     (e_scale),
    .size      (e_size),
    .seg_base  (e_seg_base),
    .seg_limit (e_seg_limit),
    .ea        (c_ea),
    .lin       (c_lin),
    .fault     (c_fault),
    .split     (c_split),
    .half2     (c_half2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    ld_ch   = 1'b0;
    ld_h2   = 1'b0;
    ld_nm   = 1'b0;
    clr     = 1'b0;
    if (flush) begin
      state_n = IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!any) begin
              ld_nm = 1'b1;
            end else begin
              ld_ch = 1'b1;
              if (c_fault)     state_n = IDLE;
              else if (c_split) state_n = SPLIT2;
              else if (more)    state_n = CHAN;
            end
          end else if (pop) begin
            clr = 1'b1;
          end
        end
        CHAN: begin
          if (pop) begin
            ld_ch = 1'b1;
            if (c_fault)      state_n = IDLE;
            else if (c_split) state_n = SPLIT2;
            else if (!more)   state_n = IDLE;
          end
        end
        SPLIT2: begin
          if (pop) begin
            ld_h2   = 1'b1;
            state_n = h2_last ? IDLE : CHAN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_is_mem    <= '0;
      cap_base      <= '0;
      cap_index     <= '0;
      cap_disp      <= '0;
      cap_use_base  <= '0;
      cap_use_index <= '0;
      cap_scale     <= '0;
      cap_size      <= '0;
      cap_seg_base  <= '0;
      cap_seg_limit <= '0;
      cap_payload   <= '0;
    end else if (accept) begin
      cap_is_mem    <= in_is_mem;
      cap_base      <= in_base;
      cap_index     <= in_index;
      cap_disp      <= in_disp;
      cap_use_base  <= in_use_base;
      cap_use_index <= in_use_index;
      cap_scale     <= in_scale;
      cap_size      <= in_size;
      cap_seg_base  <= in_seg_base;
      cap_seg_limit <= in_seg_limit;
      cap_payload   <= in_payload;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_chan    <= '0;
      out_mem     <= 1'b0;
      out_split   <= 1'b0;
      out_half    <= 1'b0;
      out_fault   <= 1'b0;
      out_last    <= 1'b0;
      out_size    <= '0;
      out_payload <= '0;
      cur         <= '0;
      h2_addr     <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (ld_nm) begin
      out_valid   <= 1'b1;
      out_addr    <= '0;
      out_chan    <= '0;
      out_mem     <= 1'b0;
      out_split   <= 1'b0;
      out_half    <= 1'b0;
      out_fault   <= 1'b0;
      out_last    <= 1'b1;
      out_size    <= '0;
      out_payload <= in_payload;
    end else if (ld_ch) begin
      out_valid   <= 1'b1;
      out_addr    <= c_lin;
      out_chan    <= ch;
      out_mem     <= 1'b1;
      out_split   <= c_split;
      out_half    <= 1'b0;
      out_fault   <= c_fault;
      out_last    <= c_fault || (!c_split && !more);
      out_size    <= e_size;
      out_payload <= accept ? in_payload : cap_payload;
      cur         <= ch;
      h2_addr     <= c_half2;
    end else if (ld_h2) begin
      out_addr  <= h2_addr;
      out_split <= 1'b1;
      out_half  <= 1'b1;
      out_fault <= 1'b0;
      out_last  <= h2_last;
    end
  end

endmodule

// File: tb/tb_agen_stage.sv
// tb_agen_stage: directed vectors with hand-computed beats for agen_stage.
// Drives and samples on the falling edge.
module tb_agen_stage;

  localparam int AW  = 32;
  localparam int NCH = 2;
  localparam int PW  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [NCH-1:0]    in_is_mem;
  logic [NCH*AW-1:0] in_base, in_index, in_disp;
  logic [NCH-1:0]    in_use_base, in_use_index;
  logic [NCH*2-1:0]  in_scale, in_size;
  logic [NCH*AW-1:0] in_seg_base, in_seg_limit;
  logic [PW-1:0]     in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [0:0]    out_chan;
  logic          out_mem, out_split, out_half;
  logic          out_fault, out_last;
  logic [1:0]    out_size;
  logic [PW-1:0] out_payload;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  agen_stage #(
    .AW(AW), .NCH(NCH), .LINE_B(64), .PAY_W(PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_mem    (in_is_mem),
    .in_base      (in_base),
    .in_index     (in_index),
    .in_disp      (in_disp),
    .in_use_base  (in_use_base),
    .in_use_index (in_use_index),
    .in_scale     (in_scale),
    .in_size      (in_size),
    .in_seg_base  (in_seg_base),
    .in_seg_limit (in_seg_limit),
    .in_payload   (in_payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_chan     (out_chan),
    .out_mem      (out_mem),
    .out_split    (out_split),
    .out_half     (out_half),
    .out_fault    (out_fault),
    .out_last     (out_last),
    .out_size     (out_size),
    .out_payload  (out_payload)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    in_valid     = 1'b0;
    in_is_mem    = '0;
    in_base      = '0;
    in_index     = '0;
    in_disp      = '0;
    in_use_base  = '0;
    in_use_index = '0;
    in_scale     = '0;
    in_size      = '0;
    in_seg_base  = '0;
    in_seg_limit = '0;
    in_payload   = '0;
  endtask

  task automatic set_ch(input int c,
                        input logic [31:0] b, ix, d,
                        input logic ub, ui,
                        input logic [1:0] sc, sz,
                        input logic [31:0] sb, lim);
    in_is_mem[c]           = 1'b1;
    in_base[c*AW +: AW]    = b;
    in_index[c*AW +: AW]   = ix;
    in_disp[c*AW +: AW]    = d;
    in_use_base[c]         = ub;
    in_use_index[c]        = ui;
    in_scale[c*2 +: 2]     = sc;
    in_size[c*2 +: 2]      = sz;
    in_seg_base[c*AW +: AW]  = sb;
    in_seg_limit[c*AW +: AW] = lim;
  endtask

  // Called at a falling edge; returns at the falling edge after accept.
  task automatic push();
    int t;
    t = 0;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("push_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks the beat presented now, then advances one cycle.
  task automatic exp_beat(input string tag,
                          input logic [31:0] addr,
                          input logic ch, mem, spl, half,
                          input logic flt, last,
                          input logic [1:0] sz,
                          input logic [63:0] pay);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".addr"},  64'(out_addr),  64'(addr));
    chk({tag, ".chan"},  64'(out_chan),  64'(ch));
    chk({tag, ".mem"},   64'(out_mem),   64'(mem));
    chk({tag, ".split"}, 64'(out_split), 64'(spl));
    chk({tag, ".half"},  64'(out_half),  64'(half));
    chk({tag, ".fault"}, 64'(out_fault), 64'(flt));
    chk({tag, ".last"},  64'(out_last),  64'(last));
    chk({tag, ".size"},  64'(out_size),  64'(sz));
    chk({tag, ".pay"},   out_payload,    pay);
    @(negedge clk);
  endtask

  task automatic txn_basic();
    clr_in();
    set_ch(0, 32'h1000, 32'h10, 32'h8, 1, 1, 2'd2, 2'd2,
           32'h20000, 32'hFFFF);
    in_payload = 64'hA1;
  endtask

  task automatic txn_split();
    clr_in();
    set_ch(0, 32'h3E, 0, 0, 1, 0, 2'd0, 2'd2, 0, 32'hFFFF);
    in_payload = 64'hB2;
  endtask

  task automatic txn_two();
    clr_in();
    set_ch(0, 32'h100, 0, 0, 1, 0, 2'd0, 2'd3,
           32'h1000, 32'hFFFF);
    set_ch(1, 32'h200, 0, 32'h4, 1, 0, 2'd0, 2'd0,
           32'h2000, 32'hFFFF);
    in_payload = 64'hD4;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    clr_in();
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.valid2",   64'(out_valid), 64'd0);

    // Basic EA + segment base
    txn_basic();
    push();
    exp_beat("t1", 32'h21048, 0, 1, 0, 0, 0, 1, 2'd2, 64'hA1);
    chk("t1.idle", 64'(out_valid), 64'd0);

    // Line split
    txn_split();
    push();
    exp_beat("t2a", 32'h3E, 0, 1, 1, 0, 0, 0, 2'd2, 64'hB2);
    exp_beat("t2b", 32'h40, 0, 1, 1, 1, 0, 1, 2'd2, 64'hB2);
    chk("t2.idle", 64'(out_valid), 64'd0);

    // Limit fault drops ch1
    clr_in();
    set_ch(0, 32'hFFE, 0, 0, 1, 0, 2'd0, 2'd2, 0, 32'h0FFF);
    set_ch(1, 32'h100, 0, 0, 1, 0, 2'd0, 2'd0, 0, 32'hFFFF);
    in_payload = 64'hC3;
    push();
    exp_beat("t3", 32'hFFE, 0, 1, 0, 0, 1, 1, 2'd2, 64'hC3);
    chk("t3.no_ch1", 64'(out_valid), 64'd0);

    // Backpressure
    txn_two();
    out_ready = 1'b0;
    push();
    for (int i = 0; i < 3; i++) begin
      chk("t4.hold_v",  64'(out_valid), 64'd1);
      chk("t4.hold_a",  64'(out_addr),  64'h1100);
      chk("t4.hold_l",  64'(out_last),  64'd0);
      chk("t4.in_rdy",  64'(in_ready),  64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp_beat("t4a", 32'h1100, 0, 1, 0, 0, 0, 0, 2'd3, 64'hD4);
    exp_beat("t4b", 32'h2204, 1, 1, 0, 0, 0, 1, 2'd0, 64'hD4);
    chk("t4.idle", 64'(out_valid), 64'd0);

    // Back-to-back non-memory transactions
    clr_in();
    for (int k = 1; k <= 5; k++) begin
      chk("t5.in_rdy", 64'(in_ready), 64'd1);
      in_payload = 64'(k);
      in_valid   = 1'b1;
      @(negedge clk);
      chk("t5.valid", 64'(out_valid),   64'd1);
      chk("t5.mem",   64'(out_mem),     64'd0);
      chk("t5.addr",  64'(out_addr),    64'd0);
      chk("t5.last",  64'(out_last),    64'd1);
      chk("t5.pay",   out_payload,      64'(k));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5.idle", 64'(out_valid), 64'd0);

    // Address wrap
    clr_in();
    set_ch(0, 32'hFFFFFFF0, 0, 32'h20, 1, 0, 2'd0, 2'd0,
           0, 32'hFFFFFFFF);
    in_payload = 64'hE5;
    push();
    exp_beat("t5w", 32'h10, 0, 1, 0, 0, 0, 1, 2'd0, 64'hE5);

    // Async reset while in SPLIT2
    txn_split();
    push();
    chk("t6.pre_split", 64'(out_split), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6.r_valid", 64'(out_valid),   64'd0);
    chk("t6.r_addr",  64'(out_addr),    64'd0);
    chk("t6.r_split", 64'(out_split),   64'd0);
    chk("t6.r_mem",   64'(out_mem),     64'd0);
    chk("t6.r_last",  64'(out_last),    64'd0);
    chk("t6.r_pay",   out_payload,      64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6.r_rdy", 64'(in_ready), 64'd1);
    txn_basic();
    push();
    exp_beat("t6r", 32'h21048, 0, 1, 0, 0, 0, 1, 2'd2, 64'hA1);

    // Flush in CHAN, with in_valid asserted in the flush cycle
    txn_two();
    out_ready = 1'b0;
    push();
    chk("t6.f_pre", 64'(out_valid), 64'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t6.f_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6.f_quiet", 64'(out_valid), 64'd0);
    end
    txn_basic();
    push();
    exp_beat("t6f", 32'h21048, 0, 1, 0, 0, 0, 1, 2'd2, 64'hA1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/agen_stage.md
# agen_stage

Parametrised address-generation stage for the x86 pipeline, sitting between the register-read stage and the memory/TLB stage. Each accepted transaction carries up to NCH memory-operand descriptors. For each descriptor the block computes the effective address, the segment-linear address, a segment limit check and cache-line split detection. It then serialises the results into one output beat per memory access (two beats for a split access), with valid/ready handshakes on both sides.

## Interface
- AW, 32: address width.
- NCH, 2: memory-operand channels per transaction (≥1).
- LINE_B, 64: cache line size in bytes (power of 2, ≥8).
- PAY_W, 64: passthrough payload width (op, imm, sr1, far_jmp, …).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards the captured transaction and the output beat.
- in_valid / in_ready  in/out  1  input handshake.
- in_is_mem  in  NCH  channel is a memory operand.
- in_base, in_index, in_disp  in  NCH×AW  per-channel EA terms.
- in_use_base, in_use_index  in  NCH  per-channel term enables (disabled term = 0).
- in_scale  in  NCH×2  index shift 0..3.
- in_size  in  NCH×2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
- in_seg_base, in_seg_limit  in  NCH×AW  segment base and limit.
- in_payload  in  PAY_W  copied unchanged onto every beat of the transaction.
- out_valid / out_ready  out/in  1  output handshake.
- out_addr  out  AW  linear address of the beat.
- out_chan  out  clog2(NCH) (min 1)  source channel.
- out_mem, out_split, out_half, out_fault, out_last  out  1  beat flags.
- out_size  out  2  access size.
- out_payload  out  PAY_W  payload.

## Operation
- ea = (use_base?base:0) + ((use_index?index:0) << scale) + disp, mod 2^AW.
- lin = seg_base + ea, mod 2^AW.
- bytes = 1 << size.
- fault = (ea + bytes − 1) > seg_limit. The comparison is unsigned in AW+1 bits.
- split = (lin mod LINE_B) + bytes > LINE_B, and only when there is no fault.
- Second-half address = (lin & ~(LINE_B−1)) + LINE_B, mod 2^AW.
- The FSM has three states: IDLE, CHAN, SPLIT2.
- IDLE:
  - in_ready = !out_valid || out_ready.
  - On accept, the transaction is captured and the first beat is loaded into the output register.
  - If that beat is the last beat, the FSM stays in IDLE; otherwise it moves to CHAN, or to SPLIT2 if the first beat is split.
- CHAN: on each output pop, load the next is_mem channel in ascending order. Go to SPLIT2 if that channel is split.
- SPLIT2:
  - On pop, load the second half: out_half=1, out_split=1, same chan, size and payload.
  - Then go to CHAN, or to IDLE if it was the final beat.
- A transaction with no is_mem channel emits a single beat: out_mem=0, out_addr=0, out_last=1.
- A fault ends the transaction:
  - The faulting beat has out_fault=1 and out_last=1, and is never split.
  - Later channels are dropped.
- out_last=1 only on the final beat of a transaction.
- in_ready is low in CHAN and SPLIT2.
- Output register rules:
  - Holds its contents while out_valid && !out_ready.
  - The beat is stable until popped.
- flush has priority over accept and over load:
  - Next cycle: state=IDLE, out_valid=0.
  - in_valid in the flush cycle is ignored.

## Timing
- Latency: accept at edge k gives out_valid=1 from edge k (registered, visible the cycle after the accept cycle).
- Throughput: one beat per cycle, which allows back-to-back single-beat transactions with out_ready held high.
- Asynchronous reset (any time, including mid-split): state=IDLE and all out_* = 0. in_ready reads 1 while reset is deasserted and out_valid=0.

## Structure
- agen_pkg holds:
  - size encoding constants;
  - the state enum (IDLE, CHAN, SPLIT2);
  - a function for the next set bit at or above a given index;
  - a function for bytes-from-size.
- Sub-module agen_ea_calc: combinational ea, lin, fault, split and second-half address for one channel, parametrised by AW and LINE_B.
- agen_ea_calc is instantiated once, with its inputs muxed by the current channel index.

## Test plan
1. Basic EA and linear address.
   - Stimulus: ch0 base=0x1000, index=0x10, scale=2, disp=0x8, seg_base=0x20000, limit=0xFFFF, size=4B.
   - Expected: one beat, out_addr=0x21048, last=1, fault=0, split=0.
2. Line split.
   - Stimulus: ea=0x3E, seg_base=0, size=4B, LINE_B=64.
   - Expected beat 1: addr 0x3E, split=1, half=0, last=0.
   - Expected beat 2: addr 0x40, half=1, last=1.
3. Limit fault.
   - Stimulus: limit=0x0FFF, ch0 ea=0x0FFE size=4B, ch1 valid.
   - Expected: one beat, fault=1, last=1; no ch1 beat.
4. Backpressure.
   - Stimulus: two mem channels, out_ready low for 3 cycles.
   - Expected: ch0 beat held stable and in_ready=0 during the stall; then ch0 and ch1 beats on consecutive cycles, last on ch1.
5. No-memory transactions and address wrap.
   - Stimulus: five back-to-back non-memory transactions.
   - Expected: 5 beats in 5 cycles, each with mem=0 and last=1.
   - Stimulus: base=0xFFFFFFF0, disp=0x20.
   - Expected: out_addr=0x10.
6. Reset and flush.
   - Stimulus: rst low during SPLIT2.
   - Expected: all outputs 0 immediately; the next transaction behaves normally.
   - Stimulus: flush in CHAN.
   - Expected: out_valid=0 next cycle and no further beats from the flushed transaction.
